hub75_fb_loader: RTL and testbench

HUB75_FB_LOADER -- requirements
Module: hub75_fb_loader

---
 rtl/hub75_fb_loader_pkg.sv | 17 +
 rtl/hub75_fb_loader_addr.sv | 57 +++++
 rtl/hub75_fb_loader.sv | 123 ++++++++++++
 tb/tb_hub75_fb_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_fb_loader_pkg.sv
// Shared hub75 definitions: loader FSM encoding and the frame line-count helper.
package hub75_fb_loader_pkg;

   typedef enum logic [1:0] {
      ST_FILL       = 2'd0,
      ST_FLUSH      = 2'd1,
      ST_FRAME_WAIT = 2'd2,
      ST_WAIT_SOF   = 2'd3
   } state_t;

   // Lines per frame: every bank contributes N_ROWS lines.
   function automatic int unsigned line_count(input int unsigned n_banks,
                                              input int unsigned n_rows);
      return n_banks * n_rows;
   endfunction

endpackage

// File: rtl/hub75_fb_loader_addr.sv
// Raster position counter (col/row/bank) with modulo wrap and first/last flags.
module hub75_fb_loader_addr
   import hub75_fb_loader_pkg::*;
#(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int LOG_N_BANKS = $clog2(N_BANKS),
   parameter int LOG_N_ROWS  = $clog2(N_ROWS),
   parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   col_inc,
   input  logic                   line_inc,
   output logic [LOG_N_COLS-1:0]  col,
   output logic [LOG_N_ROWS-1:0]  row,
   output logic [LOG_N_BANKS-1:0] bank,
   output logic                   first_px,
   output logic                   last_col,
   output logic                   last_line
);

   localparam int unsigned LAST_LINE = line_count(N_BANKS, N_ROWS) - 1;

   assign first_px  = (col == '0) && (row == '0) && (bank == '0);
   assign last_col  = (col == LOG_N_COLS'(N_COLS - 1));
   assign last_line = ((32'(bank) * 32'(N_ROWS)) + 32'(row)) == LAST_LINE;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         bank <= '0;
      end else if (clr) begin
         // Restart at line 0; a pixel consumed on the same cycle occupies col 0.
         col  <= col_inc ? LOG_N_COLS'(1) : '0;
         row  <= '0;
         bank <= '0;
      end else begin
         if (col_inc) begin
            col <= last_col ? '0 : col + 1'b1;
         end
         if (line_inc) begin
            if (row == LOG_N_ROWS'(N_ROWS - 1)) begin
               row  <= '0;
               bank <= (bank == LOG_N_BANKS'(N_BANKS - 1)) ? '0 : bank + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hub75_fb_loader.sv
// Streams raster pixels into a HUB75 line buffer, storing rows and swapping frames.
// Optional SOF resynchronisation: define HUB75_FB_LOADER_SOF_RESYNC_EN.
module hub75_fb_loader
   import hub75_fb_loader_pkg::*;
#(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int BITDEPTH    = 24,
   parameter int LOG_N_BANKS = $clog2(N_BANKS),
   parameter int LOG_N_ROWS  = $clog2(N_ROWS),
   parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BITDEPTH-1:0]    in_data,
   input  logic                   in_sof,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [LOG_N_BANKS-1:0] wr_bank_addr,
   output logic [LOG_N_ROWS-1:0]  wr_row_addr,
   output logic                   wr_row_store,
   input  logic                   wr_row_rdy,
   output logic                   wr_row_swap,
   output logic [BITDEPTH-1:0]    wr_data,
   output logic [LOG_N_COLS-1:0]  wr_col_addr,
   output logic                   wr_en,
   output logic                   frame_swap,
   output logic                   frame_done,
   output logic                   sof_err
);

`ifdef HUB75_FB_LOADER_SOF_RESYNC_EN
   localparam state_t RESET_STATE = ST_WAIT_SOF;
`else
   localparam state_t RESET_STATE = ST_FILL;
`endif

   state_t                  state;
   logic [LOG_N_COLS-1:0]   col;
   logic                    first_px, last_col, last_line;
   logic                    accept, store, sof_hit, col_inc, sof_err_q;

   assign in_ready = (state == ST_FILL) || (state == ST_WAIT_SOF);
   assign accept   = in_valid && in_ready;

   // The store waits out the cycle carrying the line's final write.
   assign store        = (state == ST_FLUSH) && wr_row_rdy && !wr_en;
   assign wr_row_store = store;
   assign wr_row_swap  = store;
   assign frame_swap   = (state == ST_FRAME_WAIT) && wr_row_rdy;
   assign frame_done   = frame_swap;
   assign sof_err      = sof_err_q;

`ifdef HUB75_FB_LOADER_SOF_RESYNC_EN
   assign sof_hit = accept && in_sof && ((state == ST_WAIT_SOF) || !first_px);
   assign col_inc = accept && ((state == ST_FILL) || sof_hit);
`else
   logic unused_sof;
   assign unused_sof = in_sof ^ first_px;
   assign sof_hit    = 1'b0;
   assign col_inc    = accept;
`endif

   hub75_fb_loader_addr #(
      .N_BANKS     (N_BANKS),
      .N_ROWS      (N_ROWS),
      .N_COLS      (N_COLS),
      .LOG_N_BANKS (LOG_N_BANKS),
      .LOG_N_ROWS  (LOG_N_ROWS),
      .LOG_N_COLS  (LOG_N_COLS)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .clr       (sof_hit),
      .col_inc   (col_inc),
      .line_inc  (store),
      .col       (col),
      .row       (wr_row_addr),
      .bank      (wr_bank_addr),
      .first_px  (first_px),
      .last_col  (last_col),
      .last_line (last_line)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RESET_STATE;
         wr_en       <= 1'b0;
         wr_data     <= '0;
         wr_col_addr <= '0;
         sof_err_q   <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         sof_err_q <= 1'b0;
         if (col_inc) begin
            wr_en       <= 1'b1;
            wr_data     <= in_data;
            wr_col_addr <= sof_hit ? '0 : col;
         end
         case (state)
            ST_FILL: begin
               if (sof_hit) begin
                  sof_err_q <= 1'b1;
               end else if (accept && last_col) begin
                  state <= ST_FLUSH;
               end
            end
            ST_WAIT_SOF: begin
               if (sof_hit) state <= ST_FILL;
            end
            ST_FLUSH: begin
               if (store) state <= last_line ? ST_FRAME_WAIT : ST_FILL;
            end
            ST_FRAME_WAIT: begin
               if (wr_row_rdy) state <= ST_FILL;
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Scoreboard bench for hub75_fb_loader at 2 banks x 4 rows x 8 cols x 24 bits.
module tb_hub75_fb_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] in_data = '0;
   logic        in_sof = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        wr_bank_addr;
   logic [1:0]  wr_row_addr;
   logic        wr_row_store;
   logic        wr_row_rdy = 1'b1;
   logic        wr_row_swap;
   logic [23:0] wr_data;
   logic [2:0]  wr_col_addr;
   logic        wr_en;
   logic        frame_swap;
   logic        frame_done;
   logic        sof_err;

   always #5 clk = ~clk;

   hub75_fb_loader #(
      .N_BANKS (2),
      .N_ROWS  (4),
      .N_COLS  (8),
      .BITDEPTH(24)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_sof       (in_sof),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .wr_bank_addr (wr_bank_addr),
      .wr_row_addr  (wr_row_addr),
      .wr_row_store (wr_row_store),
      .wr_row_rdy   (wr_row_rdy),
      .wr_row_swap  (wr_row_swap),
      .wr_data      (wr_data),
      .wr_col_addr  (wr_col_addr),
      .wr_en        (wr_en),
      .frame_swap   (frame_swap),
      .frame_done   (frame_done),
      .sof_err      (sof_err)
   );

   typedef struct {
      logic [23:0] d;
      logic [2:0]  col;
      logic        bank;
      logic [1:0]  row;
      logic        se;
   } wr_t;

   typedef struct {
      logic       bank;
      logic [1:0] row;
   } st_t;

   wr_t  wq[$];
   st_t  sq[$];
   int   fq[$];
   int   errors = 0;
   int   checks = 0;
   logic special_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event present, none expected at %0t", name, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write, store or frame event.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (wq.size() == 0) begin
               flag("unexpected_wr_en");
            end else begin
               wr_t w;
               w = wq.pop_front();
               check("write", {wr_data, wr_col_addr, wr_bank_addr, wr_row_addr, sof_err},
                     {w.d, w.col, w.bank, w.row, w.se});
            end
         end else if (sof_err) begin
            flag("sof_err_without_write");
         end
         if (wr_row_store) begin
            if (sq.size() == 0) begin
               flag("unexpected_store");
            end else begin
               st_t s;
               s = sq.pop_front();
               check("store", {wr_bank_addr, wr_row_addr, wr_row_swap}, {s.bank, s.row, 1'b1});
            end
         end else if (wr_row_swap) begin
            flag("swap_without_store");
         end
         if (frame_swap) begin
            if (fq.size() == 0) begin
               flag("unexpected_frame_swap");
            end else begin
               void'(fq.pop_front());
               check("frame_done", 64'(frame_done), 64'd1);
            end
         end else if (frame_done) begin
            flag("frame_done_without_swap");
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] pix(input int y, input int x);
      if (special_en && y == 3 && x == 5) return 24'h123456;
      return 24'hA00000 | 24'(y << 8) | 24'(x);
   endfunction

   task automatic push_wr(input logic [23:0] d, input int y, input int x, input logic se);
      wr_t w;
      w.d    = d;
      w.col  = 3'(x);
      w.bank = 1'(y / 4);
      w.row  = 2'(y % 4);
      w.se   = se;
      wq.push_back(w);
   endtask

   task automatic push_st(input int y);
      st_t s;
      s.bank = 1'(y / 4);
      s.row  = 2'(y % 4);
      sq.push_back(s);
   endtask

   // One transfer; returns 1 ns after the accepting edge.
   task automatic send(input logic [23:0] d, input logic sof);
      int t = 0;
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         flag("in_ready_timeout");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_line(input int y, input int x0);
      for (int x = x0; x < 8; x++) begin
         push_wr(pix(y, x), y, x, 1'b0);
         send(pix(y, x), (y == 0 && x == 0));
      end
      push_st(y);
      if (y == 7) fq.push_back(1);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_store", 64'({wr_row_store, wr_row_swap}), 64'd0);
      check("rst_frame", 64'({frame_swap, frame_done}), 64'd0);
      check("rst_sof_err", 64'(sof_err), 64'd0);
      check("rst_addr", 64'({wr_bank_addr, wr_row_addr, wr_col_addr}), 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      idle(1);

      // Full frame; line 2 stalls on wr_row_rdy; (3,5) carries 0x123456.
      special_en = 1'b1;
      send_line(0, 0);
      send_line(1, 0);
      idle(2);
      wr_row_rdy = 1'b0;
      send_line(2, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_no_store", 64'(wr_row_store), 64'd0);
      end
      @(posedge clk);
      #1 wr_row_rdy = 1'b1;
      @(negedge clk);
      check("store_on_rdy_rise", 64'(wr_row_store), 64'd1);
      for (int y = 3; y < 8; y++) send_line(y, 0);
      special_en = 1'b0;
      idle(5);

      // Reset while line 5 waits in FLUSH: its store and the frame swap never happen.
      for (int y = 0; y < 5; y++) send_line(y, 0);
      idle(2);
      wr_row_rdy = 1'b0;
      for (int x = 0; x < 8; x++) begin
         push_wr(pix(5, x), 5, x, 1'b0);
         send(pix(5, x), 1'b0);
      end
      idle(3);
      do_reset();
      wr_row_rdy = 1'b1;
      for (int y = 0; y < 8; y++) send_line(y, 0);
      idle(5);

`ifdef HUB75_FB_LOADER_SOF_RESYNC_EN
      do_reset();
      for (int i = 0; i < 3; i++) send(24'h0BAD00 | 24'(i), 1'b0);
      send_line(0, 0);
      send_line(1, 0);
      for (int x = 0; x < 4; x++) begin
         push_wr(pix(2, x), 2, x, 1'b0);
         send(pix(2, x), 1'b0);
      end
      push_wr(24'h5EED00, 0, 0, 1'b1);
      send(24'h5EED00, 1'b1);
      send_line(0, 1);
      for (int y = 1; y < 8; y++) send_line(y, 0);
      idle(5);
`endif

      idle(10);
      check("writes_drained", 64'(wq.size()), 64'd0);
      check("stores_drained", 64'(sq.size()), 64'd0);
      check("frames_drained", 64'(fq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
